alu_issue_buffer: RTL and testbench
===================================

# alu_issue_buffer

Initiator side of the ALU operand interface: accepts decoded RV32 integer micro-ops, translates funct3/funct7/immediate/count information into the 4-bit ALU op code, and queues them in a small FIFO. It drives A, B and op into the combinational ALU, then captures F/Zero with the micro-op tag in a registered result slot. It sits between the dispatch stage and writeback, one instance per ALU lane.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- TAG_W, 5, micro-op tag width (ROB/physical-dest tag)
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- in_valid_i  in  1  micro-op offered
- in_ready_o  out  1  buffer can accept (registered)
- in_funct3_i  in  3  RV32 funct3
- in_f7b30_i  in  1  instruction bit 30
- in_is_imm_i  in  1  OP-IMM form (B is immediate)
- in_is_cnt_i  in  1  count op; B[1:0] selects the count function
- in_a_i, in_b_i  in  32  operands
- in_tag_i  in  TAG_W  tag
- alu_a_o, alu_b_o  out  32  to ALU A/B
- alu_op_o  out  4  to ALU op
- alu_f_i  in  32  ALU F
- alu_zero_i  in  1  ALU Zero (equals F[0])
- res_valid_o  out  1  result held
- res_ready_i  in  1  writeback consumes result
- res_data_o  out  32 ; res_zero_o  out  1 ; res_tag_o  out  TAG_W ; res_err_o  out  1  illegal op flag

## Operation
- Op encoding (package constants): ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 1010, SLT 0100, SLTU 0101, SLL 0110, SRL 0111, SRA 1110, CNT 1111.
- funct3 map: 000 ADD (SUB if !is_imm && f7b30); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA by f7b30; 110 OR; 111 AND. is_cnt overrides to CNT.
- Illegal: SLL with f7b30=1; ADD with is_imm=0 and f7b30 ignored otherwise legal; CNT with B[1:0]=11. Illegal entries flow through with err=1, res_data_o=0, res_zero_o=0.
- Encoding happens at enqueue; FIFO stores {op, err, A, B, tag}.
- alu_*_o driven combinationally from FIFO head; 0 when FIFO empty.
- Pop when head valid and (!res_valid_o || res_ready_i); the same edge loads the result slot with alu_f_i, alu_zero_i, the head tag and the head err.
- Result slot clears when res_ready_i && res_valid_o and no pop occurs in the same cycle.

## Timing
- Reset: in_ready_o=1, res_valid_o=0, res_data_o=0, res_zero_o=0, res_tag_o=0, res_err_o=0, FIFO empty, alu_*_o=0. Reset mid-operation discards every queued and held op with no partial outputs.
- Latency: accept at cycle N into an empty buffer → head at N+1 → res_valid_o at N+2. Sustained throughput is 1 op per cycle while res_ready_i=1.
- in_ready_o = count < DEPTH, computed from the registered count. Push when full is impossible because in_ready_o=0.
- Simultaneous push and pop keeps count unchanged. Pointers wrap modulo DEPTH.
- res_valid_o && !res_ready_i stalls: the result and all res_* outputs stay stable, and the head stays on alu_*_o.

## Configuration
- ALU_ISSUE_CNT_EN defined: in_is_cnt_i is honoured and encodes CNT (1111).
- Not defined: CNT is never produced. Any in_is_cnt_i=1 op is marked illegal (err=1, data 0).

## Structure
- Package alu_pkg holds the alu_op_t 4-bit typedef, the op constants above, and the funct3 constants.
- One combinational sub-module, alu_op_encoder: inputs funct3, f7b30, is_imm, is_cnt, B[1:0]; outputs op and err.
- FIFO storage and the result slot are inline.

## Test plan
- Reset, then idle → in_ready_o=1, res_valid_o=0, alu_op_o=0000.
- ADD A=5, B=7, tag 3, res_ready_i=1 → alu_op_o=0000 at N+1; res_data_o=12, res_tag_o=3, res_err_o=0 at N+2.
- R-type funct3=000 with f7b30=1, A=3, B=5 → op 0001, res_data_o=0xFFFFFFFE. OP-IMM funct3=101 with f7b30=1 → op 1110.
- Hold res_ready_i=0 and push 6 ops → in_ready_o drops after the buffer holds DEPTH+1 ops (4 in FIFO, 1 in the slot). Release → results drain in order with tags unchanged.
- SLL with f7b30=1 → res_err_o=1, res_data_o=0. is_cnt=1 with B=0 → op 1111 if ALU_ISSUE_CNT_EN is defined, else err=1.
- rst_i asserted with 3 ops queued and a result held → next cycle res_valid_o=0, in_ready_o=1. No stale result appears afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32 funct3 codes and the queued micro-op payload.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t OP_ADD  = 4'b0000;
    localparam alu_op_t OP_SUB  = 4'b0001;
    localparam alu_op_t OP_AND  = 4'b0010;
    localparam alu_op_t OP_OR   = 4'b0011;
    localparam alu_op_t OP_XOR  = 4'b1010;
    localparam alu_op_t OP_SLT  = 4'b0100;
    localparam alu_op_t OP_SLTU = 4'b0101;
    localparam alu_op_t OP_SLL  = 4'b0110;
    localparam alu_op_t OP_SRL  = 4'b0111;
    localparam alu_op_t OP_SRA  = 4'b1110;
    localparam alu_op_t OP_CNT  = 4'b1111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        alu_op_t             op;
        logic                err;
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
    } alu_uop_t;

endpackage

// File: rtl/alu_op_encoder.sv
// Combinational funct3/f7b30/imm/count to ALU op translation with illegal-op flag.
// Count ops are honoured only when ALU_ISSUE_CNT_EN is defined.
module alu_op_encoder
    import alu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       f7b30,
    input  logic       is_imm,
    input  logic       is_cnt,
    input  logic [1:0] b_lo,
    output alu_op_t    op_c,
    output logic       err_c
);

    always_comb begin
        op_c  = OP_ADD;
        err_c = 1'b0;
        case (funct3)
            F3_ADD:  op_c = (!is_imm && f7b30) ? OP_SUB : OP_ADD;
            F3_SLL: begin
                op_c  = OP_SLL;
                err_c = f7b30;
            end
            F3_SLT:  op_c = OP_SLT;
            F3_SLTU: op_c = OP_SLTU;
            F3_XOR:  op_c = OP_XOR;
            F3_SR:   op_c = f7b30 ? OP_SRA : OP_SRL;
            F3_OR:   op_c = OP_OR;
            F3_AND:  op_c = OP_AND;
            default: op_c = OP_ADD;
        endcase
`ifdef ALU_ISSUE_CNT_EN
        // Count selector 11 has no defined function.
        if (is_cnt) begin
            op_c  = OP_CNT;
            err_c = (b_lo == 2'b11);
        end
`else
        if (is_cnt) begin
            err_c = 1'b1;
        end
`endif
    end

`ifndef ALU_ISSUE_CNT_EN
    logic unused_b_lo;
    assign unused_b_lo = ^b_lo;
`endif

endmodule

// File: rtl/alu_issue_buffer.sv
// ALU issue FIFO: encodes micro-ops at enqueue, feeds the ALU from the head and
// registers F/Zero with the tag in a result slot. Optional feature: ALU_ISSUE_CNT_EN.
module alu_issue_buffer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       in_funct3_i,
    input  logic             in_f7b30_i,
    input  logic             in_is_imm_i,
    input  logic             in_is_cnt_i,
    input  logic [31:0]      in_a_i,
    input  logic [31:0]      in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic [31:0]      alu_a_o,
    output logic [31:0]      alu_b_o,
    output logic [3:0]       alu_op_o,
    input  logic [31:0]      alu_f_i,
    input  logic             alu_zero_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [31:0]      res_data_o,
    output logic             res_zero_o,
    output logic [TAG_W-1:0] res_tag_o,
    output logic             res_err_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    alu_uop_t         mem     [DEPTH];
    logic [TAG_W-1:0] tag_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             empty;
    logic             push;
    logic             pop;
    alu_op_t          enc_op;
    logic             enc_err;
    alu_uop_t         head;

    alu_op_encoder u_enc (
        .funct3 (in_funct3_i),
        .f7b30  (in_f7b30_i),
        .is_imm (in_is_imm_i),
        .is_cnt (in_is_cnt_i),
        .b_lo   (in_b_i[1:0]),
        .op_c   (enc_op),
        .err_c  (enc_err)
    );

    assign empty = (count == '0);
    assign push  = in_valid_i && in_ready_o;
    assign pop   = !empty && (!res_valid_o || res_ready_i);
    assign head  = mem[rd_ptr];

    // Head drives the ALU directly; idle buffer presents zeros.
    assign alu_a_o  = empty ? '0 : head.a;
    assign alu_b_o  = empty ? '0 : head.b;
    assign alu_op_o = empty ? '0 : head.op;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Payload storage needs no reset; validity lives in count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr]     <= '{op: enc_op, err: enc_err, a: in_a_i, b: in_b_i};
            tag_mem[wr_ptr] <= in_tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_ready_o  <= 1'b1;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_zero_o  <= 1'b0;
            res_tag_o   <= '0;
            res_err_o   <= 1'b0;
        end else begin
            count      <= count_nxt;
            in_ready_o <= (count_nxt < CNT_W'(DEPTH));
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                res_valid_o <= 1'b1;
                res_data_o  <= head.err ? '0 : alu_f_i;
                res_zero_o  <= !head.err && alu_zero_i;
                res_tag_o   <= tag_mem[rd_ptr];
                res_err_o   <= head.err;
            end else if (res_valid_o && res_ready_i) begin
                res_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_buffer.sv
// Self-checking bench for alu_issue_buffer: directed scenarios plus a randomized
// run scored against an in-order reference queue and a behavioural ALU.
module tb_alu_issue_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 5;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [2:0]       in_funct3_i;
    logic             in_f7b30_i;
    logic             in_is_imm_i;
    logic             in_is_cnt_i;
    logic [31:0]      in_a_i;
    logic [31:0]      in_b_i;
    logic [TAG_W-1:0] in_tag_i;
    logic [31:0]      alu_a_o;
    logic [31:0]      alu_b_o;
    logic [3:0]       alu_op_o;
    logic [31:0]      alu_f_i;
    logic             alu_zero_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [31:0]      res_data_o;
    logic             res_zero_o;
    logic [TAG_W-1:0] res_tag_o;
    logic             res_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0]      data;
        logic             zero;
        logic             err;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic        f7;
        logic        imm;
        logic        cnt;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        err;
        logic [31:0] data;
    } enc_case_t;

    exp_t exp_q[$];

    alu_issue_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_funct3_i (in_funct3_i),
        .in_f7b30_i  (in_f7b30_i),
        .in_is_imm_i (in_is_imm_i),
        .in_is_cnt_i (in_is_cnt_i),
        .in_a_i      (in_a_i),
        .in_b_i      (in_b_i),
        .in_tag_i    (in_tag_i),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_op_o    (alu_op_o),
        .alu_f_i     (alu_f_i),
        .alu_zero_i  (alu_zero_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .res_zero_o  (res_zero_o),
        .res_tag_o   (res_tag_o),
        .res_err_o   (res_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural ALU; count selector: 00 popcount, 01 leading zeros, 10 trailing zeros.
    function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        int n;
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b1010: return a ^ b;
            4'b0100: return {31'd0, $signed(a) < $signed(b)};
            4'b0101: return {31'd0, a < b};
            4'b0110: return a << b[4:0];
            4'b0111: return a >> b[4:0];
            4'b1110: return $unsigned($signed(a) >>> b[4:0]);
            4'b1111: begin
                n = 0;
                if (b[1:0] == 2'b00) n = $countones(a);
                else if (b[1:0] == 2'b01) begin
                    while (n < 32 && a[31-n] == 1'b0) n++;
                end else if (b[1:0] == 2'b10) begin
                    while (n < 32 && a[n] == 1'b0) n++;
                end
                return 32'(n);
            end
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_f_i    = alu_calc(alu_op_o, alu_a_o, alu_b_o);
        alu_zero_i = alu_f_i[0];
    end

    // Reference decode: returns {err, op} from the instruction-level rules.
    function automatic logic [4:0] ref_decode(input logic [2:0] f3, input logic f7,
                                              input logic imm, input logic cnt,
                                              input logic [1:0] bl);
        logic [3:0] op;
        logic       err;
        err = 1'b0;
        case (f3)
            3'd0: op = (f7 && !imm) ? 4'b0001 : 4'b0000;
            3'd1: begin op = 4'b0110; err = f7; end
            3'd2: op = 4'b0100;
            3'd3: op = 4'b0101;
            3'd4: op = 4'b1010;
            3'd5: op = f7 ? 4'b1110 : 4'b0111;
            3'd6: op = 4'b0011;
            default: op = 4'b0010;
        endcase
        if (cnt) begin
`ifdef ALU_ISSUE_CNT_EN
            op  = 4'b1111;
            err = (bl == 2'b11);
`else
            err = 1'b1;
`endif
        end
        return {err, op};
    endfunction

    task automatic drive_op(input logic [2:0] f3, input logic f7, input logic imm,
                            input logic cnt, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAG_W-1:0] tag);
        in_valid_i  = 1'b1;
        in_funct3_i = f3;
        in_f7b30_i  = f7;
        in_is_imm_i = imm;
        in_is_cnt_i = cnt;
        in_a_i      = a;
        in_b_i      = b;
        in_tag_i    = tag;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        in_valid_i  = 1'b0;
        res_ready_i = 1'b0;
        rst_i       = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk_i);
        n_cmp++;
        if (in_ready_o !== 1'b1 || res_valid_o !== 1'b0 || res_data_o !== 32'd0 ||
            res_zero_o !== 1'b0 || res_tag_o !== '0 || res_err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h zero=%b tag=%0d err=%b, want 1 0 0 0 0 0",
                     in_ready_o, res_valid_o, res_data_o, res_zero_o, res_tag_o, res_err_o);
        end
        n_cmp++;
        if (alu_op_o !== 4'b0000 || alu_a_o !== 32'd0 || alu_b_o !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_alu: got op=%b a=%h b=%h, want all zero", alu_op_o, alu_a_o, alu_b_o);
        end
    endtask

    task automatic test_latency();
        res_ready_i = 1'b1;
        drive_op(3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 5'd3);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        n_cmp++;
        if (alu_op_o !== 4'b0000 || alu_a_o !== 32'd5 || alu_b_o !== 32'd7 || res_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_head: got op=%b a=%0d b=%0d vld=%b, want 0000 5 7 0",
                     alu_op_o, alu_a_o, alu_b_o, res_valid_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (res_valid_o !== 1'b1 || res_data_o !== 32'd12 || res_tag_o !== 5'd3 ||
            res_err_o !== 1'b0 || res_zero_o !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_result: got vld=%b data=%0d tag=%0d err=%b zero=%b, want 1 12 3 0 0",
                     res_valid_o, res_data_o, res_tag_o, res_err_o, res_zero_o);
        end
        n_cmp++;
        if (alu_op_o !== 4'b0000 || alu_a_o !== 32'd0) begin
            n_bad++;
            $display("FAIL latency_empty_alu: got op=%b a=%h, want 0000 0", alu_op_o, alu_a_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (res_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_consume: got vld=%b, want 0", res_valid_o);
        end
    endtask

    task automatic test_encode();
        enc_case_t cs[9];
        cs[0] = '{3'b000, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5, 4'b0001, 1'b0, 32'hFFFF_FFFE};
        cs[1] = '{3'b101, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 4'b1110, 1'b0, 32'hF800_0000};
        cs[2] = '{3'b000, 1'b1, 1'b1, 1'b0, 32'd10, 32'd20, 4'b0000, 1'b0, 32'd30};
        cs[3] = '{3'b001, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 4'b0110, 1'b1, 32'd0};
        cs[4] = '{3'b101, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 4'b0111, 1'b0, 32'h0800_0000};
        cs[5] = '{3'b100, 1'b0, 1'b1, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1010, 1'b0, 32'h0FF0_0FF0};
        cs[6] = '{3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 4'b0100, 1'b0, 32'd1};
`ifdef ALU_ISSUE_CNT_EN
        cs[7] = '{3'b000, 1'b0, 1'b0, 1'b1, 32'h0000_F0F1, 32'd0, 4'b1111, 1'b0, 32'd9};
        cs[8] = '{3'b000, 1'b0, 1'b0, 1'b1, 32'd7, 32'd3, 4'b1111, 1'b1, 32'd0};
`else
        cs[7] = '{3'b000, 1'b0, 1'b0, 1'b1, 32'h0000_F0F1, 32'd0, 4'b0000, 1'b1, 32'd0};
        cs[8] = '{3'b000, 1'b0, 1'b0, 1'b1, 32'd7, 32'd3, 4'b0000, 1'b1, 32'd0};
`endif
        res_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_op(cs[i].f3, cs[i].f7, cs[i].imm, cs[i].cnt, cs[i].a, cs[i].b, 5'(i + 1));
            @(negedge clk_i);
            in_valid_i = 1'b0;
            n_cmp++;
            if (alu_op_o !== cs[i].op) begin
                n_bad++;
                $display("FAIL encode_op[%0d]: got op=%b, want %b", i, alu_op_o, cs[i].op);
            end
            @(negedge clk_i);
            n_cmp++;
            if (res_valid_o !== 1'b1 || res_data_o !== cs[i].data || res_err_o !== cs[i].err ||
                res_zero_o !== (cs[i].data[0] && !cs[i].err) || res_tag_o !== 5'(i + 1)) begin
                n_bad++;
                $display("FAIL encode_result[%0d]: got vld=%b data=%h err=%b zero=%b tag=%0d, want 1 %h %b %b %0d",
                         i, res_valid_o, res_data_o, res_err_o, res_zero_o, res_tag_o,
                         cs[i].data, cs[i].err, cs[i].data[0] && !cs[i].err, i + 1);
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_backpressure();
        int  sent;
        int  got;
        logic acc;
        sent = 0;
        got  = 0;
        res_ready_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (sent < 6) drive_op(3'b000, 1'b0, 1'b0, 1'b0, 32'(sent), 32'd100, 5'(10 + sent));
            else in_valid_i = 1'b0;
            acc = in_valid_i && in_ready_o;
            @(negedge clk_i);
            if (acc) sent++;
        end
        n_cmp++;
        if (sent != DEPTH + 1 || in_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_fill: got accepted=%0d rdy=%b, want %0d 0", sent, in_ready_o, DEPTH + 1);
        end
        n_cmp++;
        if (res_valid_o !== 1'b1 || res_tag_o !== 5'd10 || res_data_o !== 32'd100 || alu_a_o !== 32'd1) begin
            n_bad++;
            $display("FAIL bp_stall: got vld=%b tag=%0d data=%0d head_a=%0d, want 1 10 100 1",
                     res_valid_o, res_tag_o, res_data_o, alu_a_o);
        end
        res_ready_i = 1'b1;
        for (int c = 0; c < 30 && got < 6; c++) begin
            if (sent < 6) drive_op(3'b000, 1'b0, 1'b0, 1'b0, 32'(sent), 32'd100, 5'(10 + sent));
            else in_valid_i = 1'b0;
            acc = in_valid_i && in_ready_o;
            if (res_valid_o) begin
                n_cmp++;
                if (res_tag_o !== 5'(10 + got) || res_data_o !== 32'(100 + got) || res_err_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_drain[%0d]: got tag=%0d data=%0d err=%b, want %0d %0d 0",
                             got, res_tag_o, res_data_o, res_err_o, 10 + got, 100 + got);
                end
                got++;
            end
            @(negedge clk_i);
            if (acc) sent++;
        end
        in_valid_i = 1'b0;
        n_cmp++;
        if (got != 6) begin
            n_bad++;
            $display("FAIL bp_drain_count: got %0d results, want 6", got);
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid();
        int   sent;
        logic acc;
        logic stale;
        sent  = 0;
        stale = 1'b0;
        res_ready_i = 1'b0;
        for (int c = 0; c < 10 && sent < 4; c++) begin
            drive_op(3'b110, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'(sent), 5'(20 + sent));
            acc = in_ready_o;
            @(negedge clk_i);
            if (acc) sent++;
        end
        in_valid_i = 1'b0;
        n_cmp++;
        if (res_valid_o !== 1'b1 || sent != 4) begin
            n_bad++;
            $display("FAIL rstmid_setup: got vld=%b accepted=%0d, want 1 4", res_valid_o, sent);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        n_cmp++;
        if (res_valid_o !== 1'b0 || in_ready_o !== 1'b1 || alu_op_o !== 4'b0000 ||
            alu_a_o !== 32'd0 || res_data_o !== 32'd0 || res_tag_o !== '0) begin
            n_bad++;
            $display("FAIL rstmid_clear: got vld=%b rdy=%b op=%b a=%h data=%h tag=%0d, want 0 1 0 0 0 0",
                     res_valid_o, in_ready_o, alu_op_o, alu_a_o, res_data_o, res_tag_o);
        end
        res_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (res_valid_o !== 1'b0 || alu_a_o !== 32'd0) stale = 1'b1;
        end
        n_cmp++;
        if (stale) begin
            n_bad++;
            $display("FAIL rstmid_stale: got stale result or head after reset, want none");
        end
    endtask

    task automatic test_random();
        logic [4:0] dec;
        logic       acc;
        logic       cons;
        exp_t       e;
        exp_t       g;
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            drive_op(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 7) == 0), $urandom,
                     ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom,
                     TAG_W'($urandom));
            in_valid_i  = ($urandom_range(0, 3) != 0);
            res_ready_i = ($urandom_range(0, 2) != 0);
            acc  = in_valid_i && in_ready_o;
            cons = res_valid_o && res_ready_i;
            if (res_valid_o && exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rand_unexpected: got vld=1 tag=%0d with nothing outstanding", res_tag_o);
            end else if (cons) begin
                g = exp_q.pop_front();
                n_cmp++;
                if (res_data_o !== g.data || res_zero_o !== g.zero || res_err_o !== g.err || res_tag_o !== g.tag) begin
                    n_bad++;
                    $display("FAIL rand_result: got data=%h zero=%b err=%b tag=%0d, want %h %b %b %0d",
                             res_data_o, res_zero_o, res_err_o, res_tag_o, g.data, g.zero, g.err, g.tag);
                end
            end
            if (acc) begin
                dec    = ref_decode(in_funct3_i, in_f7b30_i, in_is_imm_i, in_is_cnt_i, in_b_i[1:0]);
                e.err  = dec[4];
                e.data = dec[4] ? 32'd0 : alu_calc(dec[3:0], in_a_i, in_b_i);
                e.zero = !dec[4] && e.data[0];
                e.tag  = in_tag_i;
                exp_q.push_back(e);
            end
            @(negedge clk_i);
        end
        in_valid_i  = 1'b0;
        res_ready_i = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            if (res_valid_o) begin
                g = exp_q.pop_front();
                n_cmp++;
                if (res_data_o !== g.data || res_zero_o !== g.zero || res_err_o !== g.err || res_tag_o !== g.tag) begin
                    n_bad++;
                    $display("FAIL rand_drain: got data=%h zero=%b err=%b tag=%0d, want %h %b %b %0d",
                             res_data_o, res_zero_o, res_err_o, res_tag_o, g.data, g.zero, g.err, g.tag);
                end
            end
            @(negedge clk_i);
        end
        n_cmp++;
        if (exp_q.size() != 0 || res_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rand_leftover: got %0d outstanding vld=%b, want 0 0", exp_q.size(), res_valid_o);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_funct3_i = 3'd0;
        in_f7b30_i  = 1'b0;
        in_is_imm_i = 1'b0;
        in_is_cnt_i = 1'b0;
        in_a_i      = 32'd0;
        in_b_i      = 32'd0;
        in_tag_i    = '0;
        res_ready_i = 1'b0;
        test_reset();
        test_latency();
        test_encode();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
